mem_stage: RTL and testbench
============================

# mem_stage

Pipeline memory-access stage, directly downstream of the execute stage. Takes the registered EXU outputs, runs load/store transactions on a valid/ready data-memory port, and extracts and sign-extends load data. Holds the upstream pipeline with `mem_stall` while a transaction is in flight. Registers results for write-back.

## Interface
- `clk`  in  1  stage clock
- `rstn`  in  1  reset; synchronous, active-low
- `exu_execute_en`  in  1  EXU slot holds a valid instruction
- `exu_index_rd`  in  5  destination register
- `exu_alu_result`  in  64  memory address for load/store; ALU result otherwise
- `exu_gpr_data2`  in  64  store data
- `exu_load_en`, `exu_store_en`  in  1 each  access type; never both set
- `exu_load_opcode`  in  3  RV funct3 load kind
- `exu_store_len`  in  4  store byte count: 1, 2, 4 or 8
- `exu_wb_en`  in  1  write-back enable
- `exu_wb_choose`  in  4  write-back source select
- `exu_ebreak`  in  1  ebreak marker
- `exu_pc`, `exu_snxt_pc`  in  64 each  PC and sequential next PC
- `exu_instr`  in  32  instruction word
- `mem_stall`  out  1  combinational; upstream stages hold while high
- `dmem_req_valid`  out  1  request valid
- `dmem_req_ready`  in  1  request accepted
- `dmem_req_addr`  out  64  address, 8-byte aligned (`addr & ~7`)
- `dmem_req_wen`  out  1  1 = store
- `dmem_req_wdata`  out  64  lane-shifted store data
- `dmem_req_wmask`  out  8  byte-lane mask
- `dmem_rsp_valid`  in  1  response or write acknowledge
- `dmem_rsp_rdata`  in  64  aligned doubleword read data
- `mem_execute_en`, `mem_index_rd`, `mem_wb_en`, `mem_wb_choose`, `mem_alu_result`, `mem_snxt_pc`, `mem_pc`, `mem_instr`, `mem_ebreak`  out  registered copies for WB
- `mem_load_data`  out  64  extended load result
- `mem_misalign`  out  1  misaligned access flag

## Operation
- A memory op is `exu_execute_en & (exu_load_en | exu_store_en)`.
- FSM states:
  - IDLE: a memory op drives `dmem_req_valid=1` combinationally from the EXU inputs. On ready, go to RESP; otherwise go to REQ.
  - REQ: re-drive the request from latched copies until ready, then go to RESP.
  - RESP: wait for `dmem_rsp_valid`, then go to IDLE.
- Request fields: `wen` = store; `wmask = ((1<<len)-1) << addr[2:0]`, truncated to 8 bits; `wdata = gpr_data2 << (8*addr[2:0])`. Load mask = 0xFF.
- Load extraction: take `rdata >> (8*addr[2:0])`, then apply the funct3 kind:
  - 000 LB, 001 LH, 010 LW sign-extend the low 8/16/32 bits.
  - 011 LD takes all 64 bits.
  - 100 LBU, 101 LHU, 110 LWU zero-extend the low 8/16/32 bits.
  - 111 yields 0.
- `mem_stall` = (IDLE & memory op) | REQ | (RESP & ~rsp_valid).
- Output registers:
  - While stalled, they load a bubble: `mem_execute_en=0`, `mem_wb_en=0`, `mem_ebreak=0`, `mem_misalign=0`. Other fields are don't-care.
  - Otherwise they load from the EXU inputs. `mem_load_data` takes the extracted data on a load, 0 otherwise.
- An input bubble (`exu_execute_en=0`) passes through as a bubble.
- `dmem_rsp_valid` outside RESP is ignored.

## Timing
- Reset: state IDLE; every `mem_*` output 0. Combinational outputs follow from IDLE with no pending op.
- Reset mid-transaction abandons the transaction: state returns to IDLE next edge. The memory is reset by the same `rstn`.
- Non-memory instruction: 1 cycle latency, no stall.
- Load/store: 2 cycles minimum (ready in the IDLE cycle, response the following cycle).
  - Each cycle without ready adds 1 cycle.
  - Each RESP cycle without `rsp_valid` adds 1 cycle.
- The result registers on the edge ending the `rsp_valid` cycle. Upstream advances on that same edge.
- Request fields are stable from first assertion of `dmem_req_valid` until ready.

## Configuration
- `MEM_MISALIGN_CHECK_EN` defined:
  - A load/store with `addr` not a multiple of its size (derived from funct3 or `store_len`) issues no request and does not stall.
  - It retires in 1 cycle with `mem_misalign=1`, `mem_wb_en=0`, `mem_load_data=0`.
- Undefined:
  - `mem_misalign` is tied 0.
  - Misaligned accesses are issued as-is. Bytes beyond lane 7 are dropped (store mask truncated, load upper bytes read as 0 before extension).

## Structure
- `mem_pkg`: funct3 load-kind constants, store-length constants (1/2/4/8), FSM state enum (IDLE/REQ/RESP).
- Sub-module `mem_align`: combinational wmask/wdata generation, load shift-and-extend, misalign detection. The stage keeps the FSM and registers.

## Test plan
- ALU op, `exu_alu_result=0x1234`, `wb_en=1` → next cycle `mem_alu_result=0x1234`, `mem_wb_en=1`, `mem_stall` never high.
- LB at `0x80000003`, ready immediate, `rdata=0x00000000_80000000` (byte 3 = 0x80), response 1 cycle later → `mem_load_data=0xFFFFFFFF_FFFFFF80`; stall high exactly 2 cycles; `req_addr=0x80000000`. Same access as LBU → `0x80`.
- SH `data=0xBEEF` at `0x...06` → `wmask=0xC0`, `wdata=0xBEEF0000_00000000`, `wen=1`.
- Ready held low 3 cycles, then response delayed 2 cycles → request fields stable throughout; stall lasts 6 cycles; one bubble per stalled cycle into WB.
- `rstn` low during RESP → IDLE, `dmem_req_valid=0`, all `mem_*` outputs 0 next cycle; a stray `rsp_valid` afterwards is ignored.
- With `MEM_MISALIGN_CHECK_EN`: LW at `0x...02` → no request, no stall, `mem_misalign=1`, `mem_wb_en=0`. Without the macro: the same LW issues with `wmask=0xFF`.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants for the memory-access stage.
// Load funct3 kinds, store lengths and the FSM state enum.
package mem_pkg;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LD  = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;
  localparam logic [2:0] LD_LWU = 3'b110;

  localparam logic [3:0] ST_B = 4'd1;
  localparam logic [3:0] ST_H = 4'd2;
  localparam logic [3:0] ST_W = 4'd4;
  localparam logic [3:0] ST_D = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment: store mask/data, load shift+extend, misalign.
// In: off, store_en, store_len, store_data, load_op, rdata. Out: wmask, wdata, load_data, misalign.
// MEM_MISALIGN_CHECK_EN enables misalign detection.
module mem_align
  import mem_pkg::*;
(
  input  logic [2:0]  off,
  input  logic        store_en,
  input  logic [3:0]  store_len,
  input  logic [63:0] store_data,
  input  logic [2:0]  load_op,
  input  logic [63:0] rdata,
  output logic [7:0]  wmask,
  output logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic        misalign
);

  logic [15:0] mask_wide;
  logic [63:0] sh;

  // Mask built 16 bits wide; lanes past 7 fall off.
  assign mask_wide = ((16'h1 << store_len) - 16'h1) << off;
  assign wmask = store_en ? mask_wide[7:0] : 8'hFF;
  assign wdata = store_data << {off, 3'b000};
  assign sh = rdata >> {off, 3'b000};

  always_comb begin
    load_data = 64'h0;
    case (load_op)
      LD_LB:  load_data = {{56{sh[7]}}, sh[7:0]};
      LD_LH:  load_data = {{48{sh[15]}}, sh[15:0]};
      LD_LW:  load_data = {{32{sh[31]}}, sh[31:0]};
      LD_LD:  load_data = sh;
      LD_LBU: load_data = {56'h0, sh[7:0]};
      LD_LHU: load_data = {48'h0, sh[15:0]};
      LD_LWU: load_data = {32'h0, sh[31:0]};
      default: load_data = 64'h0;
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic [3:0] sz;
  logic [3:0] sz_m1;
  assign sz = store_en ? store_len
                       : (4'd1 << load_op[1:0]);
  assign sz_m1 = sz - 4'd1;
  assign misalign = |({1'b0, off} & sz_m1);
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: load/store FSM on dmem port, WB result regs.
// Ports: exu_* in, dmem_req_*/dmem_rsp_*, mem_stall, mem_* out to WB.
// MEM_MISALIGN_CHECK_EN retires misaligned accesses without a request.
module mem_stage
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        exu_execute_en,
  input  logic [4:0]  exu_index_rd,
  input  logic [63:0] exu_alu_result,
  input  logic [63:0] exu_gpr_data2,
  input  logic        exu_load_en,
  input  logic        exu_store_en,
  input  logic [2:0]  exu_load_opcode,
  input  logic [3:0]  exu_store_len,
  input  logic        exu_wb_en,
  input  logic [3:0]  exu_wb_choose,
  input  logic        exu_ebreak,
  input  logic [63:0] exu_pc,
  input  logic [63:0] exu_snxt_pc,
  input  logic [31:0] exu_instr,
  output logic        mem_stall,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [63:0] dmem_req_addr,
  output logic        dmem_req_wen,
  output logic [63:0] dmem_req_wdata,
  output logic [7:0]  dmem_req_wmask,
  input  logic        dmem_rsp_valid,
  input  logic [63:0] dmem_rsp_rdata,
  output logic        mem_execute_en,
  output logic [4:0]  mem_index_rd,
  output logic        mem_wb_en,
  output logic [3:0]  mem_wb_choose,
  output logic [63:0] mem_alu_result,
  output logic [63:0] mem_snxt_pc,
  output logic [63:0] mem_pc,
  output logic [31:0] mem_instr,
  output logic        mem_ebreak,
  output logic [63:0] mem_load_data,
  output logic        mem_misalign
);

  mem_state_e state, nstate;

  logic [63:0] lat_addr, lat_data;
  logic [2:0]  lat_lop;
  logic [3:0]  lat_len;
  logic        lat_st;

  logic [63:0] cur_addr, cur_data;
  logic [2:0]  cur_lop;
  logic [3:0]  cur_len;
  logic        cur_st;

  logic [63:0] ld_ext;
  logic        mis;
  logic        mem_op;
  logic        mis_op;
  logic        issue;
  logic        idle;

  assign idle   = (state == IDLE);
  assign mem_op = exu_execute_en
                & (exu_load_en | exu_store_en);
  assign mis_op = idle & mem_op & mis;
  assign issue  = mem_op & ~mis_op;

  // Live inputs in IDLE, held copies once in flight.
  assign cur_addr = idle ? exu_alu_result : lat_addr;
  assign cur_data = idle ? exu_gpr_data2 : lat_data;
  assign cur_lop  = idle ? exu_load_opcode : lat_lop;
  assign cur_len  = idle ? exu_store_len : lat_len;
  assign cur_st   = idle ? exu_store_en : lat_st;

  mem_align u_align (
    .off        (cur_addr[2:0]),
    .store_en   (cur_st),
    .store_len  (cur_len),
    .store_data (cur_data),
    .load_op    (cur_lop),
    .rdata      (dmem_rsp_rdata),
    .wmask      (dmem_req_wmask),
    .wdata      (dmem_req_wdata),
    .load_data  (ld_ext),
    .misalign   (mis)
  );

  assign dmem_req_addr = {cur_addr[63:3], 3'b000};
  assign dmem_req_wen  = cur_st;

  always_comb begin
    nstate         = state;
    dmem_req_valid = 1'b0;
    mem_stall      = 1'b0;
    unique case (state)
      IDLE: begin
        if (issue) begin
          dmem_req_valid = 1'b1;
          mem_stall      = 1'b1;
          nstate = dmem_req_ready ? RESP : REQ;
        end
      end
      REQ: begin
        dmem_req_valid = 1'b1;
        mem_stall      = 1'b1;
        if (dmem_req_ready) nstate = RESP;
      end
      RESP: begin
        mem_stall = ~dmem_rsp_valid;
        if (dmem_rsp_valid) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= nstate;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lat_addr <= 64'h0;
      lat_data <= 64'h0;
      lat_lop  <= 3'h0;
      lat_len  <= 4'h0;
      lat_st   <= 1'b0;
    end else if (idle) begin
      lat_addr <= exu_alu_result;
      lat_data <= exu_gpr_data2;
      lat_lop  <= exu_load_opcode;
      lat_len  <= exu_store_len;
      lat_st   <= exu_store_en;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_execute_en <= 1'b0;
      mem_index_rd   <= 5'h0;
      mem_wb_en      <= 1'b0;
      mem_wb_choose  <= 4'h0;
      mem_alu_result <= 64'h0;
      mem_snxt_pc    <= 64'h0;
      mem_pc         <= 64'h0;
      mem_instr      <= 32'h0;
      mem_ebreak     <= 1'b0;
      mem_load_data  <= 64'h0;
      mem_misalign   <= 1'b0;
    end else begin
      mem_execute_en <= exu_execute_en & ~mem_stall;
      mem_index_rd   <= exu_index_rd;
      mem_wb_en      <= exu_execute_en & exu_wb_en
                      & ~mem_stall & ~mis_op;
      mem_wb_choose  <= exu_wb_choose;
      mem_alu_result <= exu_alu_result;
      mem_snxt_pc    <= exu_snxt_pc;
      mem_pc         <= exu_pc;
      mem_instr      <= exu_instr;
      mem_ebreak     <= exu_execute_en & exu_ebreak
                      & ~mem_stall;
      mem_misalign   <= mis_op & ~mem_stall;
      mem_load_data  <= (exu_execute_en & exu_load_en
                         & ~mis_op) ? ld_ext : 64'h0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage.
// Randomized loads/stores against a byte-level reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        exu_execute_en;
  logic [4:0]  exu_index_rd;
  logic [63:0] exu_alu_result;
  logic [63:0] exu_gpr_data2;
  logic        exu_load_en;
  logic        exu_store_en;
  logic [2:0]  exu_load_opcode;
  logic [3:0]  exu_store_len;
  logic        exu_wb_en;
  logic [3:0]  exu_wb_choose;
  logic        exu_ebreak;
  logic [63:0] exu_pc;
  logic [63:0] exu_snxt_pc;
  logic [31:0] exu_instr;
  logic        mem_stall;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [63:0] dmem_req_addr;
  logic        dmem_req_wen;
  logic [63:0] dmem_req_wdata;
  logic [7:0]  dmem_req_wmask;
  logic        dmem_rsp_valid;
  logic [63:0] dmem_rsp_rdata;
  logic        mem_execute_en;
  logic [4:0]  mem_index_rd;
  logic        mem_wb_en;
  logic [3:0]  mem_wb_choose;
  logic [63:0] mem_alu_result;
  logic [63:0] mem_snxt_pc;
  logic [63:0] mem_pc;
  logic [31:0] mem_instr;
  logic        mem_ebreak;
  logic [63:0] mem_load_data;
  logic        mem_misalign;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk             (clk),
    .rstn            (rstn),
    .exu_execute_en  (exu_execute_en),
    .exu_index_rd    (exu_index_rd),
    .exu_alu_result  (exu_alu_result),
    .exu_gpr_data2   (exu_gpr_data2),
    .exu_load_en     (exu_load_en),
    .exu_store_en    (exu_store_en),
    .exu_load_opcode (exu_load_opcode),
    .exu_store_len   (exu_store_len),
    .exu_wb_en       (exu_wb_en),
    .exu_wb_choose   (exu_wb_choose),
    .exu_ebreak      (exu_ebreak),
    .exu_pc          (exu_pc),
    .exu_snxt_pc     (exu_snxt_pc),
    .exu_instr       (exu_instr),
    .mem_stall       (mem_stall),
    .dmem_req_valid  (dmem_req_valid),
    .dmem_req_ready  (dmem_req_ready),
    .dmem_req_addr   (dmem_req_addr),
    .dmem_req_wen    (dmem_req_wen),
    .dmem_req_wdata  (dmem_req_wdata),
    .dmem_req_wmask  (dmem_req_wmask),
    .dmem_rsp_valid  (dmem_rsp_valid),
    .dmem_rsp_rdata  (dmem_rsp_rdata),
    .mem_execute_en  (mem_execute_en),
    .mem_index_rd    (mem_index_rd),
    .mem_wb_en       (mem_wb_en),
    .mem_wb_choose   (mem_wb_choose),
    .mem_alu_result  (mem_alu_result),
    .mem_snxt_pc     (mem_snxt_pc),
    .mem_pc          (mem_pc),
    .mem_instr       (mem_instr),
    .mem_ebreak      (mem_ebreak),
    .mem_load_data   (mem_load_data),
    .mem_misalign    (mem_misalign)
  );

  function automatic logic [7:0] m_mask(
    input logic st, input int len, input int off);
    logic [7:0] m;
    m = 8'h0;
    if (!st) return 8'hFF;
    for (int i = 0; i < 8; i++)
      if (i >= off && i < off + len) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] m_wdata(
    input logic [63:0] d, input int off);
    logic [63:0] r;
    r = 64'h0;
    for (int i = 0; i < 8; i++)
      if (i >= off) r[8*i +: 8] = d[8*(i-off) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_load(
    input logic [2:0] op, input int off,
    input logic [63:0] rd);
    logic [63:0] v, m, low;
    int sz;
    v = 64'h0;
    for (int k = 0; k < 8; k++)
      if (k + off < 8) v[8*k +: 8] = rd[8*(k+off) +: 8];
    sz = 1 << op[1:0];
    if (op == 3'd7) return 64'h0;
    if (sz == 8) return v;
    m = (64'h1 << (8*sz)) - 64'h1;
    low = v & m;
    if (op < 3'd4 && low[8*sz-1]) low = low | ~m;
    return low;
  endfunction

  task automatic idle_inputs();
    exu_execute_en = 1'b0;
    exu_load_en    = 1'b0;
    exu_store_en   = 1'b0;
    exu_wb_en      = 1'b0;
    exu_ebreak     = 1'b0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
  endtask

  task automatic run_mem_op(
    input logic ld, input logic [2:0] op,
    input logic [3:0] len, input logic [63:0] addr,
    input logic [63:0] data, input logic [63:0] rdata,
    input int rdly, input int sdly, input string nm);
    int n, stalls, off;
    logic wb;
    logic [7:0] em;
    logic [63:0] ew, el, ea, pc;
    logic [4:0] rd;
    n = rdly + sdly + 2;
    stalls = 0;
    off = int'(addr[2:0]);
    em = m_mask(!ld, int'(len), off);
    ew = m_wdata(data, off);
    el = ld ? m_load(op, off, rdata) : 64'h0;
    ea = addr & ~64'h7;
    wb = 1'($urandom_range(1));
    pc = {32'h0, $urandom};
    rd = 5'($urandom_range(31));
    exu_execute_en  = 1'b1;
    exu_load_en     = ld;
    exu_store_en    = !ld;
    exu_load_opcode = op;
    exu_store_len   = len;
    exu_alu_result  = addr;
    exu_gpr_data2   = data;
    exu_wb_en       = wb;
    exu_wb_choose   = 4'($urandom_range(15));
    exu_ebreak      = 1'b0;
    exu_pc          = pc;
    exu_snxt_pc     = pc + 64'd4;
    exu_instr       = $urandom;
    exu_index_rd    = rd;
    dmem_rsp_rdata  = rdata;
    for (int c = 0; c < n; c++) begin
      dmem_req_ready = (c == rdly);
      dmem_rsp_valid = (c == n - 1) ||
        ((c <= rdly) && ($urandom_range(1) == 1));
      #1;
      if (mem_stall) stalls++;
      checks++;
      if (mem_stall !== (c < n - 1)) begin
        errors++;
        $display("FAIL %s stall c=%0d got %b want %b",
          nm, c, mem_stall, (c < n - 1));
      end
      checks++;
      if (dmem_req_valid !== (c <= rdly)) begin
        errors++;
        $display("FAIL %s req_valid c=%0d got %b want %b",
          nm, c, dmem_req_valid, (c <= rdly));
      end
      if (c <= rdly) begin
        checks++;
        if (dmem_req_addr !== ea || dmem_req_wen !== !ld ||
            dmem_req_wmask !== em) begin
          errors++;
          $display("FAIL %s req c=%0d got %h/%b/%h want %h/%b/%h",
            nm, c, dmem_req_addr, dmem_req_wen,
            dmem_req_wmask, ea, !ld, em);
        end
        if (!ld) begin
          checks++;
          if (dmem_req_wdata !== ew) begin
            errors++;
            $display("FAIL %s wdata c=%0d got %h want %h",
              nm, c, dmem_req_wdata, ew);
          end
        end
      end
      @(posedge clk); #1;
      if (c < n - 1) begin
        checks++;
        if (mem_execute_en !== 1'b0 || mem_wb_en !== 1'b0) begin
          errors++;
          $display("FAIL %s bubble c=%0d got %b%b want 00",
            nm, c, mem_execute_en, mem_wb_en);
        end
      end
    end
    idle_inputs();
    checks++;
    if (stalls != n - 1) begin
      errors++;
      $display("FAIL %s stall_cycles got %0d want %0d",
        nm, stalls, n - 1);
    end
    checks++;
    if (mem_execute_en !== 1'b1 || mem_wb_en !== wb ||
        mem_misalign !== 1'b0 || mem_index_rd !== rd) begin
      errors++;
      $display("FAIL %s retire got %b%b%b rd%0d want 1%b0 rd%0d",
        nm, mem_execute_en, mem_wb_en, mem_misalign,
        mem_index_rd, wb, rd);
    end
    checks++;
    if (mem_load_data !== el || mem_alu_result !== addr ||
        mem_pc !== pc) begin
      errors++;
      $display("FAIL %s result got %h/%h want %h/%h",
        nm, mem_load_data, mem_alu_result, el, addr);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle_inputs();
    exu_alu_result = 64'hDEAD;
    exu_index_rd = 5'd7;
    exu_load_opcode = 3'd0;
    exu_store_len = 4'd1;
    exu_gpr_data2 = 64'h0;
    exu_wb_choose = 4'h0;
    exu_pc = 64'h0;
    exu_snxt_pc = 64'h0;
    exu_instr = 32'h0;
    dmem_rsp_rdata = 64'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mem_execute_en !== 0 || mem_wb_en !== 0 ||
        mem_alu_result !== 0 || mem_index_rd !== 0 ||
        mem_load_data !== 0 || mem_misalign !== 0 ||
        mem_ebreak !== 0) begin
      errors++;
      $display("FAIL reset_regs got %b%b %h want 00 0",
        mem_execute_en, mem_wb_en, mem_alu_result);
    end
    checks++;
    if (mem_stall !== 0 || dmem_req_valid !== 0) begin
      errors++;
      $display("FAIL reset_comb got %b%b want 00",
        mem_stall, dmem_req_valid);
    end
    rstn = 1'b1;
  endtask

  task automatic test_alu();
    exu_execute_en = 1'b1;
    exu_alu_result = 64'h1234;
    exu_wb_en      = 1'b1;
    exu_wb_choose  = 4'h3;
    exu_index_rd   = 5'd9;
    #1;
    checks++;
    if (mem_stall !== 0 || dmem_req_valid !== 0) begin
      errors++;
      $display("FAIL alu_comb got %b%b want 00",
        mem_stall, dmem_req_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (mem_alu_result !== 64'h1234 || mem_wb_en !== 1 ||
        mem_execute_en !== 1 || mem_wb_choose !== 4'h3 ||
        mem_index_rd !== 5'd9 || mem_load_data !== 0) begin
      errors++;
      $display("FAIL alu got %h %b%b want 1234 11",
        mem_alu_result, mem_wb_en, mem_execute_en);
    end
    exu_execute_en = 1'b0;
    exu_ebreak = 1'b1;
    exu_load_en = 1'b1;
    #1;
    checks++;
    if (mem_stall !== 0 || dmem_req_valid !== 0) begin
      errors++;
      $display("FAIL bubble_comb got %b%b want 00",
        mem_stall, dmem_req_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (mem_execute_en !== 0 || mem_wb_en !== 0 ||
        mem_ebreak !== 0) begin
      errors++;
      $display("FAIL bubble_in got %b%b%b want 000",
        mem_execute_en, mem_wb_en, mem_ebreak);
    end
    idle_inputs();
  endtask

  task automatic test_load_ext();
    run_mem_op(1'b1, 3'b000, 4'd1, 64'h80000003, 64'h0,
      64'h00000000_80000000, 0, 1, "lb");
    run_mem_op(1'b1, 3'b100, 4'd1, 64'h80000003, 64'h0,
      64'h00000000_80000000, 0, 1, "lbu");
    run_mem_op(1'b1, 3'b111, 4'd1, 64'h80000000, 64'h0,
      64'hFFFF_FFFF_FFFF_FFFF, 0, 0, "f3_7");
  endtask

  task automatic test_store();
    run_mem_op(1'b0, 3'b000, 4'd2, 64'h1006,
      64'hBEEF, 64'h0, 0, 0, "sh");
  endtask

  task automatic test_slow();
    run_mem_op(1'b1, 3'b011, 4'd8, 64'h4000,
      64'h0, 64'h0123_4567_89AB_CDEF, 3, 2, "slow_ld");
    run_mem_op(1'b0, 3'b000, 4'd4, 64'h4004,
      64'hCAFE_F00D, 64'h0, 3, 2, "slow_sw");
  endtask

  task automatic test_reset_mid();
    exu_execute_en  = 1'b1;
    exu_load_en     = 1'b1;
    exu_load_opcode = 3'b011;
    exu_alu_result  = 64'h5008;
    exu_wb_en       = 1'b1;
    dmem_req_ready  = 1'b1;
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    #1;
    checks++;
    if (mem_stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_resp stall got %b want 1",
        mem_stall);
    end
    rstn = 1'b0;
    exu_execute_en = 1'b0;
    exu_load_en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mem_execute_en !== 0 || mem_wb_en !== 0 ||
        mem_alu_result !== 0 || mem_load_data !== 0 ||
        dmem_req_valid !== 0 || mem_stall !== 0) begin
      errors++;
      $display("FAIL rst_mid got %b%b %h %b%b want 00 0 00",
        mem_execute_en, mem_wb_en, mem_alu_result,
        dmem_req_valid, mem_stall);
    end
    rstn = 1'b1;
    dmem_rsp_valid = 1'b1;
    #1;
    checks++;
    if (mem_stall !== 0 || dmem_req_valid !== 0) begin
      errors++;
      $display("FAIL stray_rsp got %b%b want 00",
        mem_stall, dmem_req_valid);
    end
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    checks++;
    if (mem_execute_en !== 0) begin
      errors++;
      $display("FAIL stray_rsp_wb got %b want 0",
        mem_execute_en);
    end
    run_mem_op(1'b1, 3'b010, 4'd4, 64'h6004, 64'h0,
      64'h8765_4321_0000_0000, 1, 0, "post_rst");
  endtask

  task automatic test_misalign();
`ifdef MEM_MISALIGN_CHECK_EN
    exu_execute_en  = 1'b1;
    exu_load_en     = 1'b1;
    exu_load_opcode = 3'b010;
    exu_alu_result  = 64'h2002;
    exu_wb_en       = 1'b1;
    dmem_rsp_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    checks++;
    if (mem_stall !== 0 || dmem_req_valid !== 0) begin
      errors++;
      $display("FAIL mis_comb got %b%b want 00",
        mem_stall, dmem_req_valid);
    end
    @(posedge clk); #1;
    idle_inputs();
    checks++;
    if (mem_misalign !== 1 || mem_wb_en !== 0 ||
        mem_execute_en !== 1 || mem_load_data !== 0) begin
      errors++;
      $display("FAIL mis_ret got %b%b%b %h want 101 0",
        mem_misalign, mem_wb_en, mem_execute_en,
        mem_load_data);
    end
`else
    run_mem_op(1'b1, 3'b010, 4'd4, 64'h2002, 64'h0,
      64'h1122_3344_5566_7788, 0, 0, "mis_lw");
    run_mem_op(1'b0, 3'b000, 4'd8, 64'h3005,
      64'h0102_0304_0506_0708, 64'h0, 1, 0, "mis_sd");
`endif
  endtask

  task automatic test_random();
    logic ld;
    logic [2:0] op;
    logic [3:0] len;
    logic [63:0] addr;
    int sz;
    for (int i = 0; i < 40; i++) begin
      ld = 1'($urandom_range(1));
      op = 3'($urandom_range(7));
      len = 4'(1 << $urandom_range(3));
      sz = ld ? (1 << op[1:0]) : int'(len);
      addr = {$urandom, $urandom};
      addr = addr & ~(64'(sz) - 64'h1);
      run_mem_op(ld, op, len, addr,
        {$urandom, $urandom}, {$urandom, $urandom},
        int'($urandom_range(3)),
        int'($urandom_range(3)), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_ext();
    test_store();
    test_slow();
    test_reset_mid();
    test_misalign();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
